// File: rtl/ip_mem_pkg.sv
// Shared constants for the input-peripheral register block: register
// indices inside the 32-byte window and the default window placement.
package ip_mem_pkg;

  localparam logic [2:0] IDX_SW     = 3'd0;
  localparam logic [2:0] IDX_SWEDGE = 3'd1;
  localparam logic [2:0] IDX_BTN    = 3'd4;
  localparam logic [2:0] IDX_EDGE   = 3'd5;
  localparam logic [2:0] IDX_DBLIM  = 3'd6;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_7800;
  localparam int          WINDOW_BYTES      = 32;

endpackage

// File: rtl/input_periph_regs_if.sv
// LSU load/store bus as seen by the input-peripheral register block.
// There is no handshake: a write is a one-cycle i_lsu_wren strobe with
// address and data valid in that cycle, and o_ip_data answers the address
// presented in the previous cycle.
interface input_periph_regs_if;

  logic [31:0] i_lsu_addr;
  logic        i_lsu_wren;
  logic [31:0] i_st_data;
  logic [31:0] o_ip_data;

  modport master (output i_lsu_addr, output i_lsu_wren, output i_st_data,
                  input  o_ip_data);
  modport slave  (input  i_lsu_addr, input  i_lsu_wren, input  i_st_data,
                  output o_ip_data);

endinterface

// File: rtl/btn_debounce.sv
// Debouncer for one already-synchronised button. The level changes only
// after the input has disagreed with it for eff_lim consecutive cycles
// (a limit of 0 behaves as 1). o_rise pulses in the cycle the level is
// about to go 0->1 so the caller can latch it alongside the level update.
module btn_debounce #(
  parameter int DB_WIDTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_in,
  input  logic [DB_WIDTH-1:0] i_lim,
  output logic                o_level,
  output logic                o_rise
);

  logic [DB_WIDTH-1:0] cnt_q, cnt_d;
  logic [DB_WIDTH-1:0] lim_m1;
  logic                lvl_q, lvl_d;
  logic                flip;

  // A limit already exceeded by cnt flips on the next mismatch.
  assign lim_m1 = (i_lim == '0) ? '0 : i_lim - DB_WIDTH'(1);
  assign flip   = (i_in != lvl_q) && (cnt_q >= lim_m1);

  // Next-state: restart on agreement, flip when the run is long enough.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (i_in == lvl_q) begin
      cnt_d = '0;
    end else if (flip) begin
      lvl_d = i_in;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DB_WIDTH'(1);
    end
  end

  // Counter and debounced level registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign o_level = lvl_q;
  assign o_rise  = flip & i_in;

endmodule

// File: rtl/input_periph_regs.sv
// Input-peripheral register block on the LSU load path: synchronised
// switches, debounced buttons, sticky W1C button-press flags and a
// programmable debounce limit, read back through a registered data port.
// Optional feature macro: IP_MEM_SW_EDGE_EN adds a sticky per-switch
// change register (SWEDGE) at index 1 and folds it into o_btn_evt.
module input_periph_regs
  import ip_mem_pkg::*;
#(
  parameter int                  NUM_SW    = 32,
  parameter int                  NUM_BTN   = 4,
  parameter logic [31:0]         BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int                  DB_WIDTH  = 16,
  parameter logic [DB_WIDTH-1:0] DB_RESET  = DB_WIDTH'(50000)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input_periph_regs_if.slave       lsu,
  input  logic [NUM_SW-1:0]        i_io_sw,
  input  logic [NUM_BTN-1:0]       i_io_btn,
  output logic                     o_btn_evt
);

  localparam int WIN_LSB = $clog2(WINDOW_BYTES);

  logic [NUM_SW-1:0]   sw_s1_q, sw_s2_q;
  logic [NUM_BTN-1:0]  btn_s1_q, btn_s2_q;
  logic [NUM_BTN-1:0]  btn_db, btn_rise;
  logic [NUM_BTN-1:0]  btn_edge_q, btn_edge_d;
  logic [DB_WIDTH-1:0] dblim_q, dblim_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                evt_q, evt_d;
  logic                hit;
  logic [2:0]          idx;
  logic                wr_edge, wr_dblim;
  logic                unused_ok;

  assign hit      = (lsu.i_lsu_addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign idx      = lsu.i_lsu_addr[4:2];
  assign wr_edge  = lsu.i_lsu_wren && hit && (idx == IDX_EDGE);
  assign wr_dblim = lsu.i_lsu_wren && hit && (idx == IDX_DBLIM);

  // Byte offset and write-data bits beyond each register are don't-care.
  assign unused_ok = ^{lsu.i_lsu_addr[1:0], lsu.i_st_data};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    btn_debounce #(.DB_WIDTH(DB_WIDTH)) u_db (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_in    (btn_s2_q[g]),
      .i_lim   (dblim_q),
      .o_level (btn_db[g]),
      .o_rise  (btn_rise[g])
    );
  end

`ifdef IP_MEM_SW_EDGE_EN
  logic [NUM_SW-1:0] sw_prev_q, sw_edge_q, sw_edge_d;
  logic              wr_swedge;

  assign wr_swedge = lsu.i_lsu_wren && hit && (idx == IDX_SWEDGE);

  // Sticky switch-change flags; a new change wins over a same-cycle clear.
  always_comb begin
    sw_edge_d = (sw_edge_q & ~(wr_swedge ? lsu.i_st_data[NUM_SW-1:0] : '0))
              | (sw_s2_q ^ sw_prev_q);
  end

  // Previous synchronised switch value and change flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_prev_q <= '0;
      sw_edge_q <= '0;
    end else begin
      sw_prev_q <= sw_s2_q;
      sw_edge_q <= sw_edge_d;
    end
  end
`endif

  // Sticky press flags, limit update, event OR and read mux.
  always_comb begin
    btn_edge_d = (btn_edge_q & ~(wr_edge ? lsu.i_st_data[NUM_BTN-1:0] : '0))
               | btn_rise;
    dblim_d    = wr_dblim ? lsu.i_st_data[DB_WIDTH-1:0] : dblim_q;
`ifdef IP_MEM_SW_EDGE_EN
    evt_d      = (|btn_edge_d) | (|sw_edge_d);
`else
    evt_d      = |btn_edge_d;
`endif
    rdata_d    = '0;
    if (hit) begin
      case (idx)
        IDX_SW:     rdata_d = 32'(sw_s2_q);
`ifdef IP_MEM_SW_EDGE_EN
        IDX_SWEDGE: rdata_d = 32'(sw_edge_q);
`endif
        IDX_BTN:    rdata_d = 32'(btn_db);
        IDX_EDGE:   rdata_d = 32'(btn_edge_q);
        IDX_DBLIM:  rdata_d = 32'(dblim_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  // Synchronisers and register state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_edge_q <= '0;
      dblim_q    <= DB_RESET;
      rdata_q    <= '0;
      evt_q      <= 1'b0;
    end else begin
      sw_s1_q    <= i_io_sw;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= i_io_btn;
      btn_s2_q   <= btn_s1_q;
      btn_edge_q <= btn_edge_d;
      dblim_q    <= dblim_d;
      rdata_q    <= rdata_d;
      evt_q      <= evt_d;
    end
  end

  assign lsu.o_ip_data = rdata_q;
  assign o_btn_evt     = evt_q;

endmodule
